// File: rtl/word_asm_pkg.sv
// Shared types and helpers for the word assembler: lane-count width, control states, lane placement.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package word_asm_pkg;

    // FILL: collecting symbols; DRAIN: a flush is waiting for the output slot.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } asm_state_t;

    // Width needed to count 0..lanes symbols.
    function automatic int lane_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    // Bit offset of the k-th arriving symbol within the output word.
    function automatic int lane_off(input int k, input int in_w, input int lanes, input bit msb_first);
        if (msb_first) begin
            return in_w * (lanes - 1 - k);
        end
        return in_w * k;
    endfunction

endpackage

// File: rtl/word_asm_lane_cnt.sv
// Modulo-LANES symbol counter with increment, synchronous clear and last-lane flag.
// Latency: count updates on the clock edge after inc/clr; wrap is decoded from the register.
// Backpressure: none; the caller only pulses inc on accepted symbols.
module word_asm_lane_cnt #(
    parameter int LANES = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    assign wrap = (cnt == LAST);

    // Clear wins over increment; an increment on the last lane wraps to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/word_assembler.sv
// Packs LANES symbols of IN_W bits into one word, with flush of partial words and a lane-keep mask.
// Latency: word visible the cycle after the last-lane handshake; flush emits one cycle after the slot is free.
// Backpressure: in_ready drops when the last lane cannot land in a busy output slot, or while a flush drains.
module word_assembler
    import word_asm_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int LANES     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [IN_W*LANES-1:0]     out_data,
    output logic [LANES-1:0]          out_keep,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [lane_w(LANES)-1:0]  lane_cnt
);

    localparam int OUT_W = IN_W * LANES;
    localparam int CNT_W = lane_w(LANES);
    localparam bit MSB   = (MSB_FIRST != 0);

    asm_state_t         state;
    logic               flush_pend;
    logic [OUT_W-1:0]   acc;
    logic [OUT_W-1:0]   placed;
    logic [LANES-1:0]   part_keep;
    logic               slot_free;
    logic               last_lane;
    logic               in_hs;
    logic               load_full;
    logic               drain_fire;
    logic               load_part;

    // The output slot can take a new word if empty or being consumed this cycle.
    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = !flush_pend && !(last_lane && !slot_free);
    assign in_hs      = in_valid && in_ready;
    assign load_full  = in_hs && last_lane;
    assign drain_fire = flush_pend && slot_free;
    assign load_part  = drain_fire && (lane_cnt != '0);

    // Incoming symbol moved to the bit position of its arrival lane.
    assign placed = OUT_W'(in_data) << lane_off(int'(lane_cnt), IN_W, LANES, MSB);

    // Keep mask for a partial word: the first lane_cnt arrival lanes are filled.
    always_comb begin
        part_keep = '0;
        if (MSB) begin
            part_keep = ~({LANES{1'b1}} >> lane_cnt);
        end else begin
            part_keep = ~({LANES{1'b1}} << lane_cnt);
        end
    end

    word_asm_lane_cnt #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_lane_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (in_hs),
        .clr  (drain_fire),
        .cnt  (lane_cnt),
        .wrap (last_lane)
    );

    // Control FSM: a flush pulse parks us in DRAIN until the output slot is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (flush) begin
                        state      <= DRAIN;
                        flush_pend <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (slot_free) begin
                        state      <= FILL;
                        flush_pend <= 1'b0;
                    end
                end
                default: begin
                    state      <= FILL;
                    flush_pend <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator: gather lanes, wipe whenever the count returns to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load_full || drain_fire) begin
            acc <= '0;
        end else if (in_hs) begin
            acc <= acc | placed;
        end
    end

    // Output slot: load a full or flushed word, otherwise drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (load_full) begin
            out_data  <= acc | placed;
            out_keep  <= '1;
            out_valid <= 1'b1;
        end else if (load_part) begin
            out_data  <= acc;
            out_keep  <= part_keep;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
// Latency: checks are taken one half-cycle after the edge that produced them.
// Backpressure: out_ready is driven per step to exercise stalls.
module tb_word_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        in_ready_m, in_ready_l;
    logic [31:0] out_data_m, out_data_l;
    logic [3:0]  out_keep_m, out_keep_l;
    logic        out_valid_m, out_valid_l;
    logic [2:0]  lane_cnt_m, lane_cnt_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    word_assembler #(.IN_W(8), .LANES(4), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
        .flush(flush), .out_data(out_data_m), .out_keep(out_keep_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .lane_cnt(lane_cnt_m)
    );

    word_assembler #(.IN_W(8), .LANES(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .flush(flush), .out_data(out_data_l), .out_keep(out_keep_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .lane_cnt(lane_cnt_l)
    );

    // Drive one cycle of stimulus at the falling edge, then settle.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_cmp++; if (out_data_m !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 00000000", out_data_m); end
        n_cmp++; if (out_keep_m !== 4'h0) begin n_bad++; $display("FAIL rst_keep got %b want 0000", out_keep_m); end
        n_cmp++; if (out_valid_m !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid_m); end
        n_cmp++; if (lane_cnt_m !== 3'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", lane_cnt_m); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready_m !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready_m); end
    endtask

    task automatic test_msb_lsb;
        step(1'b1, 8'hDE, 1'b1, 1'b0);
        step(1'b1, 8'hAD, 1'b1, 1'b0);
        n_cmp++; if (lane_cnt_m !== 3'd1) begin n_bad++; $display("FAIL fill_cnt got %0d want 1", lane_cnt_m); end
        step(1'b1, 8'hBE, 1'b1, 1'b0);
        step(1'b1, 8'hEF, 1'b1, 1'b0);
        n_cmp++; if (lane_cnt_m !== 3'd3 || in_ready_m !== 1'b1) begin n_bad++; $display("FAIL last_lane cnt/rdy got %0d/%b want 3/1", lane_cnt_m, in_ready_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b1) begin n_bad++; $display("FAIL msb_valid got %b want 1", out_valid_m); end
        n_cmp++; if (out_data_m !== 32'hDEADBEEF) begin n_bad++; $display("FAIL msb_data got %h want deadbeef", out_data_m); end
        n_cmp++; if (out_keep_m !== 4'b1111) begin n_bad++; $display("FAIL msb_keep got %b want 1111", out_keep_m); end
        n_cmp++; if (lane_cnt_m !== 3'd0) begin n_bad++; $display("FAIL msb_cnt_wrap got %0d want 0", lane_cnt_m); end
        n_cmp++; if (out_data_l !== 32'hEFBEADDE) begin n_bad++; $display("FAIL lsb_data got %h want efbeadde", out_data_l); end
        n_cmp++; if (out_keep_l !== 4'b1111) begin n_bad++; $display("FAIL lsb_keep got %b want 1111", out_keep_l); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b0) begin n_bad++; $display("FAIL msb_consumed got %b want 0", out_valid_m); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(i + 1), 1'b1, 1'b0);
        end
        n_cmp++; if (in_ready_m !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy_c3 got %b want 1", in_ready_m); end
        // First word out; downstream stalls for three cycles while bytes keep coming.
        step(1'b1, 8'h05, 1'b0, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b1 || out_data_m !== 32'h01020304) begin n_bad++; $display("FAIL b2b_word1 got %b/%h want 1/01020304", out_valid_m, out_data_m); end
        n_cmp++; if (in_ready_m !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy_c4 got %b want 1", in_ready_m); end
        step(1'b1, 8'h06, 1'b0, 1'b0);
        n_cmp++; if (out_data_m !== 32'h01020304 || in_ready_m !== 1'b1) begin n_bad++; $display("FAIL b2b_hold_c5 got %h/%b want 01020304/1", out_data_m, in_ready_m); end
        step(1'b1, 8'h07, 1'b0, 1'b0);
        n_cmp++; if (out_data_m !== 32'h01020304 || out_valid_m !== 1'b1 || lane_cnt_m !== 3'd2) begin n_bad++; $display("FAIL b2b_hold_c6 got %h/%b/%0d want 01020304/1/2", out_data_m, out_valid_m, lane_cnt_m); end
        step(1'b1, 8'h08, 1'b1, 1'b0);
        n_cmp++; if (lane_cnt_m !== 3'd3 || in_ready_m !== 1'b1) begin n_bad++; $display("FAIL b2b_last_free got %0d/%b want 3/1", lane_cnt_m, in_ready_m); end
        // Second word; now stall long enough to hit the last lane.
        step(1'b1, 8'h09, 1'b0, 1'b0);
        n_cmp++; if (out_data_m !== 32'h05060708 || out_keep_m !== 4'b1111 || lane_cnt_m !== 3'd0) begin n_bad++; $display("FAIL b2b_word2 got %h/%b/%0d want 05060708/1111/0", out_data_m, out_keep_m, lane_cnt_m); end
        step(1'b1, 8'h0A, 1'b0, 1'b0);
        step(1'b1, 8'h0B, 1'b0, 1'b0);
        step(1'b1, 8'h0C, 1'b0, 1'b0);
        n_cmp++; if (lane_cnt_m !== 3'd3 || in_ready_m !== 1'b0) begin n_bad++; $display("FAIL b2b_block got %0d/%b want 3/0", lane_cnt_m, in_ready_m); end
        step(1'b1, 8'h0C, 1'b0, 1'b0);
        n_cmp++; if (in_ready_m !== 1'b0 || out_data_m !== 32'h05060708) begin n_bad++; $display("FAIL b2b_block2 got %b/%h want 0/05060708", in_ready_m, out_data_m); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready_m !== 1'b1) begin n_bad++; $display("FAIL b2b_comb_rdy got %b want 1", in_ready_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_data_m !== 32'h090A0B0C || out_valid_m !== 1'b1 || lane_cnt_m !== 3'd0) begin n_bad++; $display("FAIL b2b_word3 got %h/%b/%0d want 090a0b0c/1/0", out_data_m, out_valid_m, lane_cnt_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b0) begin n_bad++; $display("FAIL b2b_drained got %b want 0", out_valid_m); end
    endtask

    task automatic test_flush_partial;
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_cmp++; if (lane_cnt_m !== 3'd2) begin n_bad++; $display("FAIL fl_cnt got %0d want 2", lane_cnt_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (in_ready_m !== 1'b0 || out_valid_m !== 1'b0) begin n_bad++; $display("FAIL fl_pend rdy/vld got %b/%b want 0/0", in_ready_m, out_valid_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b1 || out_data_m !== 32'hAABB0000 || out_keep_m !== 4'b1100) begin n_bad++; $display("FAIL fl_msb got %b/%h/%b want 1/aabb0000/1100", out_valid_m, out_data_m, out_keep_m); end
        n_cmp++; if (out_data_l !== 32'h0000BBAA || out_keep_l !== 4'b0011) begin n_bad++; $display("FAIL fl_lsb got %h/%b want 0000bbaa/0011", out_data_l, out_keep_l); end
        n_cmp++; if (lane_cnt_m !== 3'd0 || in_ready_m !== 1'b1) begin n_bad++; $display("FAIL fl_after got %0d/%b want 0/1", lane_cnt_m, in_ready_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b0) begin n_bad++; $display("FAIL fl_consumed got %b want 0", out_valid_m); end
        // Flush with nothing collected must not emit a word.
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (in_ready_m !== 1'b0 || out_valid_m !== 1'b0) begin n_bad++; $display("FAIL fl_empty_pend got %b/%b want 0/0", in_ready_m, out_valid_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin n_bad++; $display("FAIL fl_empty_word got %b/%b want 0/1", out_valid_m, in_ready_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b0) begin n_bad++; $display("FAIL fl_empty_late got %b want 0", out_valid_m); end
    endtask

    task automatic test_flush_last;
        step(1'b1, 8'h31, 1'b1, 1'b0);
        step(1'b1, 8'h32, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b1, 8'h34, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b1 || out_data_m !== 32'h31323334 || out_keep_m !== 4'b1111) begin n_bad++; $display("FAIL fll_word got %b/%h/%b want 1/31323334/1111", out_valid_m, out_data_m, out_keep_m); end
        n_cmp++; if (in_ready_m !== 1'b0) begin n_bad++; $display("FAIL fll_pend got %b want 0", in_ready_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin n_bad++; $display("FAIL fll_no_trail got %b/%b want 0/1", out_valid_m, in_ready_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b0) begin n_bad++; $display("FAIL fll_no_trail2 got %b want 0", out_valid_m); end
    endtask

    task automatic test_reset_mid;
        // Hold one word in the slot and two bytes in the accumulator, then reset.
        step(1'b1, 8'h51, 1'b0, 1'b0);
        step(1'b1, 8'h52, 1'b0, 1'b0);
        step(1'b1, 8'h53, 1'b0, 1'b0);
        step(1'b1, 8'h54, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h56, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (out_valid_m !== 1'b1 || lane_cnt_m !== 3'd2) begin n_bad++; $display("FAIL rm_pre got %b/%0d want 1/2", out_valid_m, lane_cnt_m); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid_m !== 1'b0 || out_data_m !== 32'h0 || out_keep_m !== 4'h0 || lane_cnt_m !== 3'd0) begin n_bad++; $display("FAIL rm_in_rst got %b/%h/%b/%0d want 0/00000000/0000/0", out_valid_m, out_data_m, out_keep_m, lane_cnt_m); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready_m !== 1'b1) begin n_bad++; $display("FAIL rm_rdy got %b want 1", in_ready_m); end
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b1, 8'h44, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid_m !== 1'b1 || out_data_m !== 32'h11223344 || out_keep_m !== 4'b1111) begin n_bad++; $display("FAIL rm_word got %b/%h/%b want 1/11223344/1111", out_valid_m, out_data_m, out_keep_m); end
        n_cmp++; if (out_data_l !== 32'h44332211) begin n_bad++; $display("FAIL rm_word_lsb got %h want 44332211", out_data_l); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_msb_lsb();
        test_back_to_back();
        test_flush_partial();
        test_flush_last();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
